// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing one SD sector channel between NREQ requesters.
// Grant is registered 1 cycle after request; ack/strobes routed combinationally to the granted requester.
module sd_req_arbiter #(
  parameter int          NREQ    = 4,
  parameter logic [23:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_rd,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [32*NREQ-1:0] req_lba,
  input  logic [8*NREQ-1:0] req_din,
  output logic [NREQ-1:0]   req_done,
  output logic [NREQ-1:0]   req_err,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   req_dout_strobe,
  output logic [NREQ-1:0]   req_din_strobe,
  output logic              busy,
  output logic [1:0]        grant_idx,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  output logic [7:0]        sd_din,
  input  logic              sd_ack,
  input  logic              sd_dout_strobe,
  input  logic              sd_din_strobe
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

  state_t          state, state_nxt;
  logic [1:0]      rr_ptr, rr_ptr_nxt, grant_nxt, sel;
  logic [23:0]     cnt, cnt_nxt;
  logic [31:0]     lba_nxt, sel_lba;
  logic            rd_nxt, wr_nxt, hit, sel_wr, active, grant_pend;
  logic [NREQ-1:0] pend, grant_oh, done_nxt, err_nxt;

  function automatic logic [1:0] wrap(input int v);
    return 2'(v % NREQ);
  endfunction

  assign pend       = req_rd | req_wr;
  assign grant_pend = |(pend & grant_oh);
  assign active     = (state == ISSUE) || (state == XFER);
  assign busy       = (state != IDLE);

  assign req_ack         = {NREQ{active & sd_ack}} & grant_oh;
  assign req_dout_strobe = {NREQ{active & sd_dout_strobe}} & grant_oh;
  assign req_din_strobe  = {NREQ{active & sd_din_strobe}} & grant_oh;

  // First pending requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!hit && pend[wrap(int'(rr_ptr) + k)]) begin
        hit = 1'b1;
        sel = wrap(int'(rr_ptr) + k);
      end
    end
  end

  always_comb begin
    sel_lba  = '0;
    sel_wr   = 1'b0;
    grant_oh = '0;
    sd_din   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == 2'(i)) begin
        sel_lba = req_lba[32*i +: 32];
        sel_wr  = req_wr[i];
      end
      if (grant_idx == 2'(i)) begin
        grant_oh[i] = 1'b1;
        sd_din      = req_din[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_idx;
    lba_nxt    = sd_lba;
    rd_nxt     = sd_rd;
    wr_nxt     = sd_wr;
    rr_ptr_nxt = rr_ptr;
    cnt_nxt    = cnt;
    done_nxt   = '0;
    err_nxt    = '0;
    case (state)
      IDLE: begin
        if (hit) begin
          grant_nxt = sel;
          lba_nxt   = sel_lba;
          wr_nxt    = sel_wr;
          rd_nxt    = ~sel_wr;
          cnt_nxt   = '0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt = cnt + 24'd1;
        // Ack takes precedence over both withdrawal and timeout.
        if (sd_ack) begin
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          state_nxt = XFER;
        end else if (!grant_pend) begin
          rd_nxt     = 1'b0;
          wr_nxt     = 1'b0;
          rr_ptr_nxt = wrap(int'(grant_idx) + 1);
          state_nxt  = IDLE;
        end else if (cnt == TIMEOUT - 24'd1) begin
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          err_nxt   = grant_oh;
          state_nxt = DONE;
        end
      end
      XFER: begin
        if (!sd_ack) begin
          done_nxt  = grant_oh;
          state_nxt = DONE;
        end
      end
      DONE: begin
        rr_ptr_nxt = wrap(int'(grant_idx) + 1);
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant_idx <= '0;
      sd_lba    <= '0;
      sd_rd     <= 1'b0;
      sd_wr     <= 1'b0;
      rr_ptr    <= '0;
      cnt       <= '0;
      req_done  <= '0;
      req_err   <= '0;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_nxt;
      sd_lba    <= lba_nxt;
      sd_rd     <= rd_nxt;
      sd_wr     <= wr_nxt;
      rr_ptr    <= rr_ptr_nxt;
      cnt       <= cnt_nxt;
      req_done  <= done_nxt;
      req_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Self-checking bench for sd_req_arbiter: scenario tasks against a round-robin reference model.
module tb_sd_req_arbiter;

  logic         clk_sys = 1'b0;
  logic         reset_n;
  logic [3:0]   req_rd, req_wr;
  logic [127:0] req_lba;
  logic [31:0]  req_din;
  logic [3:0]   req_done, req_err, req_ack, req_dout_strobe, req_din_strobe;
  logic         busy;
  logic [1:0]   grant_idx;
  logic [31:0]  sd_lba;
  logic         sd_rd, sd_wr;
  logic [7:0]   sd_din;
  logic         sd_ack, sd_dout_strobe, sd_din_strobe;

  int tests = 0;
  int fails = 0;
  int exp_ptr = 0;

  sd_req_arbiter #(.NREQ(4), .TIMEOUT(24'd16)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba), .req_din(req_din),
    .req_done(req_done), .req_err(req_err), .req_ack(req_ack),
    .req_dout_strobe(req_dout_strobe), .req_din_strobe(req_din_strobe),
    .busy(busy), .grant_idx(grant_idx), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_din(sd_din), .sd_ack(sd_ack), .sd_dout_strobe(sd_dout_strobe), .sd_din_strobe(sd_din_strobe)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: first pending requester searching upward from ptr, modulo 4.
  function automatic int rr_pick(input logic [3:0] pend, input int ptr);
    for (int k = 0; k < 4; k++)
      if (pend[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_rd = '0; req_wr = '0; req_lba = '0; req_din = '0;
    sd_ack = 1'b0; sd_dout_strobe = 1'b0; sd_din_strobe = 1'b0;
    step(); step();
    reset_n = 1'b1;
    exp_ptr = 0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (sd_rd !== 1'b0 || sd_wr !== 1'b0) begin fails++; $display("FAIL reset_cmd: rd=%b wr=%b want 0 0", sd_rd, sd_wr); end
    tests++; if (sd_lba !== 32'h0) begin fails++; $display("FAIL reset_lba: got %h want 0", sd_lba); end
    tests++; if (grant_idx !== 2'd0) begin fails++; $display("FAIL reset_grant: got %0d want 0", grant_idx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (req_done !== 4'h0 || req_err !== 4'h0) begin fails++; $display("FAIL reset_pulses: done=%b err=%b want 0", req_done, req_err); end
  endtask

  task automatic test_single_read();
    int g;
    req_rd = 4'b0100;
    req_lba[64 +: 32] = 32'h0000_1234;
    g = rr_pick(req_rd | req_wr, exp_ptr);
    step();
    tests++; if (sd_rd !== 1'b1 || sd_wr !== 1'b0) begin fails++; $display("FAIL single_cmd: rd=%b wr=%b want 1 0", sd_rd, sd_wr); end
    tests++; if (sd_lba !== 32'h0000_1234) begin fails++; $display("FAIL single_lba: got %h want 00001234", sd_lba); end
    tests++; if (int'(grant_idx) !== g) begin fails++; $display("FAIL single_grant: got %0d want %0d", grant_idx, g); end
    sd_ack = 1'b1; #1;
    tests++; if (req_ack !== 4'b0100) begin fails++; $display("FAIL single_ack_route: got %b want 0100", req_ack); end
    step();
    tests++; if (sd_rd !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL single_xfer: rd=%b busy=%b want 0 1", sd_rd, busy); end
    for (int n = 0; n < 512; n++) begin
      sd_dout_strobe = 1'b1; #1;
      tests++; if (req_dout_strobe !== 4'b0100) begin fails++; $display("FAIL single_strobe%0d: got %b want 0100", n, req_dout_strobe); end
      step();
      sd_dout_strobe = 1'b0; #1;
      tests++; if (req_dout_strobe !== 4'b0000) begin fails++; $display("FAIL single_strobe_low%0d: got %b want 0000", n, req_dout_strobe); end
    end
    sd_ack = 1'b0;
    step();
    tests++; if (req_done !== 4'b0100 || busy !== 1'b1) begin fails++; $display("FAIL single_done: done=%b busy=%b want 0100 1", req_done, busy); end
    req_rd = '0;
    step();
    tests++; if (req_done !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL single_idle: done=%b busy=%b want 0000 0", req_done, busy); end
    exp_ptr = (g + 1) % 4;
  endtask

  task automatic test_round_robin();
    logic [3:0]  pend;
    logic [31:0] lba_exp;
    int g, exp_g;
    do_reset();
    for (int t = 0; t < 10; t++) begin
      pend = (t < 5) ? 4'hF : 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) req_lba[32*i +: 32] = $urandom();
      req_rd = pend; req_wr = '0;
      g = rr_pick(pend, exp_ptr);
      exp_g = (t < 5) ? (t % 4) : g;
      lba_exp = req_lba[32*g +: 32];
      step();
      tests++; if (int'(grant_idx) !== exp_g) begin fails++; $display("FAIL rr_grant%0d: got %0d want %0d", t, grant_idx, exp_g); end
      tests++; if (sd_lba !== lba_exp || sd_rd !== 1'b1) begin fails++; $display("FAIL rr_issue%0d: lba=%h rd=%b want %h 1", t, sd_lba, sd_rd, lba_exp); end
      repeat ($urandom_range(0, 3)) step();
      sd_ack = 1'b1; #1;
      tests++; if (req_ack !== 4'(1 << g)) begin fails++; $display("FAIL rr_ack%0d: got %b want %b", t, req_ack, 4'(1 << g)); end
      repeat (5) step();
      sd_ack = 1'b0;
      step();
      tests++; if (req_done !== 4'(1 << g)) begin fails++; $display("FAIL rr_done%0d: got %b want %b", t, req_done, 4'(1 << g)); end
      if (t >= 4) req_rd = '0;
      step();
      tests++; if (busy !== 1'b0 || req_done !== 4'h0) begin fails++; $display("FAIL rr_turn%0d: busy=%b done=%b want 0 0000", t, busy, req_done); end
      exp_ptr = (g + 1) % 4;
    end
  endtask

  task automatic test_conflict();
    int g;
    logic [31:0] lba_exp;
    logic [7:0]  din;
    req_rd = 4'b0010; req_wr = 4'b0010;
    req_lba[32 +: 32] = $urandom();
    lba_exp = req_lba[32 +: 32];
    g = rr_pick(req_rd | req_wr, exp_ptr);
    step();
    tests++; if (sd_wr !== 1'b1 || sd_rd !== 1'b0) begin fails++; $display("FAIL conflict_cmd: wr=%b rd=%b want 1 0", sd_wr, sd_rd); end
    tests++; if (int'(grant_idx) !== g) begin fails++; $display("FAIL conflict_grant: got %0d want %0d", grant_idx, g); end
    req_lba[32 +: 32] = ~lba_exp;
    sd_ack = 1'b1;
    step();
    tests++; if (sd_lba !== lba_exp) begin fails++; $display("FAIL conflict_lba_hold: got %h want %h", sd_lba, lba_exp); end
    for (int n = 0; n < 8; n++) begin
      din = 8'($urandom());
      req_din = $urandom();
      req_din[15:8] = din;
      sd_din_strobe = n[0]; #1;
      tests++; if (sd_din !== din) begin fails++; $display("FAIL conflict_din%0d: got %h want %h", n, sd_din, din); end
      tests++; if (req_din_strobe !== (n[0] ? 4'b0010 : 4'b0000) || req_dout_strobe !== 4'h0) begin fails++; $display("FAIL conflict_strobe%0d: din_s=%b dout_s=%b", n, req_din_strobe, req_dout_strobe); end
      step();
    end
    sd_din_strobe = 1'b0; sd_ack = 1'b0;
    step();
    tests++; if (req_done !== 4'b0010) begin fails++; $display("FAIL conflict_done: got %b want 0010", req_done); end
    req_rd = '0; req_wr = '0;
    step();
    exp_ptr = (g + 1) % 4;
  endtask

  task automatic test_timeout();
    int g;
    req_rd = 4'b0001;
    g = rr_pick(req_rd, exp_ptr);
    step();
    tests++; if (sd_rd !== 1'b1 || int'(grant_idx) !== g) begin fails++; $display("FAIL timeout_issue: rd=%b grant=%0d want 1 %0d", sd_rd, grant_idx, g); end
    for (int n = 1; n < 16; n++) begin
      step();
      tests++; if (sd_rd !== 1'b1 || req_err !== 4'h0) begin fails++; $display("FAIL timeout_wait%0d: rd=%b err=%b want 1 0000", n, sd_rd, req_err); end
    end
    step();
    tests++; if (sd_rd !== 1'b0 || req_err !== 4'b0001 || req_done !== 4'h0) begin fails++; $display("FAIL timeout_err: rd=%b err=%b done=%b want 0 0001 0000", sd_rd, req_err, req_done); end
    req_rd = '0;
    step();
    tests++; if (req_err !== 4'h0 || busy !== 1'b0) begin fails++; $display("FAIL timeout_idle: err=%b busy=%b want 0000 0", req_err, busy); end
    exp_ptr = (g + 1) % 4;
  endtask

  task automatic test_withdraw();
    int g;
    bit   pulsed;
    req_wr = 4'b1000;
    g = rr_pick(req_wr, exp_ptr);
    step();
    tests++; if (sd_wr !== 1'b1 || int'(grant_idx) !== g) begin fails++; $display("FAIL withdraw_issue: wr=%b grant=%0d want 1 %0d", sd_wr, grant_idx, g); end
    step(); step();
    req_wr = 4'b0000; req_rd = 4'b0001;
    step();
    tests++; if (sd_wr !== 1'b0 || busy !== 1'b0 || req_done !== 4'h0 || req_err !== 4'h0) begin fails++; $display("FAIL withdraw_drop: wr=%b busy=%b done=%b err=%b", sd_wr, busy, req_done, req_err); end
    exp_ptr = (g + 1) % 4;
    g = rr_pick(req_rd, exp_ptr);
    step();
    tests++; if (int'(grant_idx) !== g || sd_rd !== 1'b1) begin fails++; $display("FAIL withdraw_next: grant=%0d rd=%b want %0d 1", grant_idx, sd_rd, g); end
    sd_ack = 1'b1; step(); step();
    sd_ack = 1'b0; step();
    req_rd = '0; step();
    exp_ptr = (g + 1) % 4;
    req_wr = 4'b1000;
    g = rr_pick(req_wr, exp_ptr);
    step();
    sd_ack = 1'b1; step();
    req_wr = '0;
    step(); step();
    pulsed = (req_done !== 4'h0) || (busy !== 1'b1);
    tests++; if (pulsed) begin fails++; $display("FAIL withdraw_xfer_hold: done=%b busy=%b want 0000 1", req_done, busy); end
    sd_ack = 1'b0; step();
    tests++; if (req_done !== 4'(1 << g)) begin fails++; $display("FAIL withdraw_xfer_done: got %b want %b", req_done, 4'(1 << g)); end
    step();
    exp_ptr = (g + 1) % 4;
  endtask

  task automatic test_reset_mid_xfer();
    req_rd = 4'b0100;
    step();
    sd_ack = 1'b1; step(); step();
    reset_n = 1'b0; #1;
    tests++; if (sd_rd !== 1'b0 || sd_wr !== 1'b0 || busy !== 1'b0 || grant_idx !== 2'd0) begin fails++; $display("FAIL rst_mid_state: rd=%b wr=%b busy=%b grant=%0d", sd_rd, sd_wr, busy, grant_idx); end
    tests++; if (req_ack !== 4'h0 || req_done !== 4'h0 || req_err !== 4'h0) begin fails++; $display("FAIL rst_mid_outs: ack=%b done=%b err=%b want 0", req_ack, req_done, req_err); end
    req_rd = '0;
    step();
    reset_n = 1'b1;
    exp_ptr = 0;
    for (int n = 0; n < 4; n++) begin
      step();
      tests++; if (busy !== 1'b0 || req_ack !== 4'h0 || req_done !== 4'h0) begin fails++; $display("FAIL rst_stale_ack%0d: busy=%b ack=%b done=%b", n, busy, req_ack, req_done); end
    end
    req_rd = 4'b1010;
    step();
    tests++; if (int'(grant_idx) !== rr_pick(4'b1010, exp_ptr)) begin fails++; $display("FAIL rst_regrant: got %0d want %0d", grant_idx, rr_pick(4'b1010, exp_ptr)); end
    sd_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_conflict();
    test_timeout();
    test_withdraw();
    test_reset_mid_xfer();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sd_req_arbiter.md
Name: sd_req_arbiter

Overview:
- Shares the single SD-card emulation channel between up to NREQ sector requesters, for example several disk drive controllers. The channel consists of sd_lba, sd_rd, sd_wr, sd_ack, the data strobes and the write data.
- Grants one request at a time using a round-robin arbiter and latches that requester's LBA.
- Drives the handshake until the sector transfer completes, then reports completion or a timeout to the requester.
- Sits in clk_sys between the drive controllers and the core's SPI I/O block. That block's clk_sd is tied to clk_sys, so every input here is synchronous to clk_sys.

Parameters:
NREQ, 4, number of requesters (2..4); grant index is 2 bits.
TIMEOUT, 24'hFFFFFF, clk_sys cycles to wait in ISSUE for sd_ack before aborting.

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_rd  in  NREQ  per-requester sector read request (level, held until done/err)
req_wr  in  NREQ  per-requester sector write request (level)
req_lba  in  32*NREQ  packed LBAs, requester i at [32*i +: 32]
req_din  in  8*NREQ  packed write data, requester i at [8*i +: 8]
req_done  out  NREQ  one-cycle completion pulse
req_err  out  NREQ  one-cycle timeout pulse
req_ack  out  NREQ  sd_ack routed to the granted requester; 0 elsewhere
req_dout_strobe  out  NREQ  sd_dout_strobe routed to the granted requester
req_din_strobe  out  NREQ  sd_din_strobe routed to the granted requester
busy  out  1  high in any state other than IDLE
grant_idx  out  2  index of the current or last granted requester
sd_lba  out  32  LBA presented to the SPI I/O block
sd_rd  out  1  read command
sd_wr  out  1  write command
sd_din  out  8  req_din of the granted requester (combinational mux)
sd_ack  in  1  transfer-active acknowledge
sd_dout_strobe  in  1  read data byte strobe
sd_din_strobe  in  1  write data byte fetch strobe

Behaviour:
- Reset (asynchronous, applied whenever reset_n=0, including mid-transfer):
  - state=IDLE; sd_rd=sd_wr=0; sd_lba=0; grant_idx=0.
  - rr_ptr=0; timeout counter=0.
  - req_done=req_err=0; busy=0.
  - No done or err pulse is generated for a transfer aborted by reset.
- A requester is pending when (req_rd[i] | req_wr[i]).
- If both bits are set, write has priority and only sd_wr is driven.
- IDLE:
  - Searches from rr_ptr upward, modulo NREQ, for the first pending requester.
  - On a hit it registers grant_idx, sd_lba<=req_lba[grant], and sd_rd or sd_wr<=1, clears the counter, and moves to ISSUE.
  - Latency is 1 cycle from request to sd_rd/sd_wr high.
  - No hit: stays in IDLE.
- ISSUE:
  - Counter increments every cycle.
  - sd_ack=1: drop sd_rd/sd_wr on the next edge, go to XFER.
  - Granted requester's pending bit drops before ack: drop sd_rd/sd_wr, return to IDLE, no pulse, and rr_ptr<=grant+1.
  - Counter==TIMEOUT-1 with no ack: drop sd_rd/sd_wr, pulse req_err[grant], go to DONE.
  - sd_ack and timeout in the same cycle: ack wins.
- XFER:
  - Waits for sd_ack=0. Deassertion of the request during XFER is ignored.
  - On the falling edge of sd_ack, pulse req_done[grant] for exactly one cycle and go to DONE.
- DONE: one turnaround cycle; rr_ptr<=(grant+1) mod NREQ; then IDLE.
  - The requester must drop its request during this cycle.
  - A request still high in IDLE is treated as a new request.
- Strobe routing:
  - req_ack, req_dout_strobe and req_din_strobe are combinational, gated by one-hot(grant_idx) and by state in {ISSUE, XFER}; otherwise 0.
  - sd_din is always muxed from grant_idx.
- sd_lba is stable from ISSUE entry until the next grant; requester LBA changes after the grant are ignored.
- Fairness: with all requesters pending continuously, the grant order is i, i+1, ... modulo NREQ. No requester waits more than NREQ-1 transfers.
- sd_ack high while in IDLE (stale) is ignored and routed nowhere.

Test Plan:
- Single read: req_rd[2]=1, req_lba[2]=0x00001234 → next cycle sd_rd=1, sd_lba=0x1234, grant_idx=2; sd_ack rises → sd_rd=0; 512 sd_dout_strobe pulses appear only on req_dout_strobe[2]; sd_ack falls → req_done[2] pulses one cycle; busy drops 2 cycles later.
- Round-robin: all 4 requesters read continuously, each ack lasting 5 cycles → grant order 0,1,2,3,0; every req_done pulse matches grant_idx.
- Read+write conflict: req_rd[1]=req_wr[1]=1 → sd_wr=1, sd_rd=0; sd_din follows req_din[1]; req_din_strobe[1] mirrors sd_din_strobe.
- Timeout: TIMEOUT=16, req_rd[0]=1, no ack → after 16 cycles in ISSUE sd_rd=0, req_err[0] pulses once, req_done stays 0, IDLE reached after DONE.
- Withdraw: req_wr[3] dropped 3 cycles into ISSUE → sd_wr=0, no pulses, next pending requester 0 granted; drop during XFER → transfer completes, req_done[3] pulses.
- Reset mid-XFER: reset_n=0 while sd_ack=1 → all outputs 0 immediately, no pulse; after release with sd_ack still high, no grant occurs until a request is pending.
